// File: rtl/fir_filter_param_pkg.sv
// rtl/fir_filter_param_pkg.sv - shared width helpers and saturation for the parametrised FIR
package fir_filter_param_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int prod_w(input int dw, input int cw);
      return dw + cw;
   endfunction

   // Guard bits cover the growth of summing TAPS full-scale products.
   function automatic int acc_w(input int dw, input int cw, input int taps);
      return dw + cw + clog2(taps);
   endfunction

   function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] v, input int n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// rtl/fir_filter_param_if.sv - sample, coefficient-write and output signals of the FIR
interface fir_filter_param_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 16,
   parameter int AW     = 3
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     coef_we;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_sat;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_wdata,
      input  out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
      output out_valid, out_data, out_sat
   );
endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up arithmetic shift of the accumulator, then clamp to OUT_W
module fir_round_sat
   import fir_filter_param_pkg::*;
#(
   parameter int ACC_W = 27,
   parameter int OUT_W = 16,
   parameter int SHIFT = 7
) (
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [OUT_W-1:0] o_data,
   output logic                    o_sat
);
   localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

   // One extra bit so adding the rounding constant can never wrap.
   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_r;
   logic signed [63:0]    w_wide;
   logic signed [63:0]    w_clamp;

   assign w_sum   = {i_acc[ACC_W-1], i_acc} + HALF;
   assign w_r     = w_sum >>> SHIFT;
   assign w_wide  = {{(63 - ACC_W){w_r[ACC_W]}}, w_r};
   assign w_clamp = sat_to_n(w_wide, OUT_W);
   assign o_data  = w_clamp[OUT_W-1:0];
   assign o_sat   = (w_clamp != w_wide);
endmodule

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - direct-form FIR, writable coefficients, 3-stage pipeline, rounded and saturated output
module fir_filter_param
   import fir_filter_param_pkg::*;
#(
   parameter int TAPS     = 8,
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 8,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 7,
   parameter int COEF_RST = 16
) (
   input  logic             CLK,
   input  logic             RST,
   fir_filter_param_if.slave bus
);
   localparam int AW    = clog2(TAPS);
   localparam int PW    = prod_w(DATA_W, COEF_W);
   localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
   localparam logic signed [COEF_W-1:0] COEF_INIT = COEF_W'(COEF_RST);

   logic signed [DATA_W-1:0] r_x    [TAPS-1];
   logic signed [DATA_W-1:0] w_xn   [TAPS];
   logic signed [COEF_W-1:0] r_coef [TAPS];
   logic signed [PW-1:0]     r_p    [TAPS];
   logic                     r_v1;
   logic                     r_v2;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [OUT_W-1:0]  w_rs_data;
   logic                     w_rs_sat;
   logic                     r_out_valid;
   logic signed [OUT_W-1:0]  r_out_data;
   logic                     r_out_sat;
   logic [AW-1:0]            w_addr;

   assign w_addr = bus.coef_addr;

   // Tap k sees the newest sample at k=0 and the delay line shifted by one elsewhere.
   always_comb begin
      w_xn[0] = bus.in_data;
      for (int k = 1; k < TAPS; k++) w_xn[k] = r_x[k-1];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < TAPS - 1; k++) r_x[k] <= '0;
         for (int k = 0; k < TAPS; k++) r_p[k] <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) begin
            for (int k = 0; k < TAPS - 1; k++) r_x[k] <= w_xn[k];
            for (int k = 0; k < TAPS; k++) r_p[k] <= PW'(r_coef[k]) * PW'(w_xn[k]);
         end
      end
   end

   // Products above read r_coef before this edge's write lands.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < TAPS; k++) r_coef[k] <= COEF_INIT;
      end else if (bus.coef_we && (int'(w_addr) < TAPS)) begin
         r_coef[w_addr] <= bus.coef_wdata;
      end
   end

   always_comb begin
      w_acc_sum = '0;
      for (int k = 0; k < TAPS; k++) w_acc_sum = w_acc_sum + ACC_W'(r_p[k]);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_acc <= '0;
         r_v2  <= 1'b0;
      end else begin
         r_acc <= w_acc_sum;
         r_v2  <= r_v1;
      end
   end

   fir_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .i_acc  (r_acc),
      .o_data (w_rs_data),
      .o_sat  (w_rs_sat)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_out_valid <= r_v2;
         if (r_v2) begin
            r_out_data <= w_rs_data;
            r_out_sat  <= w_rs_sat;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - directed and random checks of fir_filter_param against a FIR reference model
module tb_fir_filter_param;

   typedef struct {
      bit     v;
      longint d;
      bit     s;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   fir_filter_param_if #(.DATA_W(16), .COEF_W(8), .OUT_W(16), .AW(3)) b8 ();
   fir_filter_param_if #(.DATA_W(16), .COEF_W(8), .OUT_W(16), .AW(3)) b6 ();

   fir_filter_param #(.TAPS(8), .DATA_W(16), .COEF_W(8), .OUT_W(16), .SHIFT(7), .COEF_RST(16))
      u_dut (.CLK(CLK), .RST(RST), .bus(b8.slave));

   fir_filter_param #(.TAPS(6), .DATA_W(16), .COEF_W(8), .OUT_W(16), .SHIFT(7), .COEF_RST(16))
      u_dut6 (.CLK(CLK), .RST(RST), .bus(b6.slave));

   longint hist [8];
   longint coef [8];
   exp_t   q [$];
   longint last_d;
   bit     last_s;
   int     checks = 0;
   int     errors = 0;
   string  phase = "init";

   // y = floor((sum coef*x + 64) / 128), limited to the 16-bit signed range.
   function automatic exp_t model_sample(input longint x);
      exp_t   e;
      longint acc;
      longint num;
      longint y;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += coef[k] * hist[k];
      num = acc + 64;
      y = (num >= 0) ? (num / 128) : -((-num + 127) / 128);
      e.v = 1'b1;
      e.s = 1'b0;
      if (y > 32767) begin
         y = 32767;
         e.s = 1'b1;
      end else if (y < -32768) begin
         y = -32768;
         e.s = 1'b1;
      end
      e.d = y;
      return e;
   endfunction

   task automatic check(input string tag, input logic signed [63:0] got, input longint expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s/%s got=%0d expected=%0d", phase, tag, got, expv);
      end
   endtask

   task automatic model_reset();
      exp_t idle;
      idle.v = 1'b0;
      idle.d = 0;
      idle.s = 1'b0;
      for (int k = 0; k < 8; k++) begin
         hist[k] = 0;
         coef[k] = 16;
      end
      q.delete();
      q.push_back(idle);
      q.push_back(idle);
      last_d = 0;
      last_s = 1'b0;
   endtask

   task automatic step(input bit v, input longint d, input bit we, input int addr, input longint wd);
      exp_t e;
      exp_t o;
      b8.in_valid   = v;
      b8.in_data    = 16'(d);
      b8.coef_we    = we;
      b8.coef_addr  = 3'(addr);
      b8.coef_wdata = 8'(wd);
      @(posedge CLK);
      #1;
      e.v = 1'b0;
      e.d = 0;
      e.s = 1'b0;
      if (v) e = model_sample(d);
      if (we && addr < 8) coef[addr] = wd;
      q.push_back(e);
      o = q.pop_front();
      check("out_valid", b8.out_valid, o.v);
      if (o.v) begin
         last_d = o.d;
         last_s = o.s;
      end
      check("out_data", $signed(b8.out_data), last_d);
      check("out_sat", b8.out_sat, last_s);
   endtask

   // Reset is asserted alongside a sample and a coefficient write that must both be lost.
   task automatic do_reset();
      RST           = 1'b1;
      b8.in_valid   = 1'b1;
      b8.in_data    = 16'sd5000;
      b8.coef_we    = 1'b1;
      b8.coef_addr  = 3'd0;
      b8.coef_wdata = -8'sd5;
      @(posedge CLK);
      #1;
      RST         = 1'b0;
      b8.in_valid = 1'b0;
      b8.coef_we  = 1'b0;
      model_reset();
      check("rst_out_valid", b8.out_valid, 0);
      check("rst_out_data", $signed(b8.out_data), 0);
      check("rst_out_sat", b8.out_sat, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0);
   endtask

   initial begin
      logic signed [15:0] rd;
      logic signed [7:0]  rc;
      bit                 gap [7];

      b8.in_valid = 1'b0; b8.in_data = '0; b8.coef_we = 1'b0; b8.coef_addr = '0; b8.coef_wdata = '0;
      b6.in_valid = 1'b0; b6.in_data = '0; b6.coef_we = 1'b0; b6.coef_addr = '0; b6.coef_wdata = '0;

      phase = "reset";
      do_reset();
      idle(2);

      phase = "impulse";
      step(1'b1, 100, 1'b0, 0, 0);
      for (int i = 0; i < 11; i++) step(1'b1, 0, 1'b0, 0, 0);
      idle(3);

      phase = "neg_impulse";
      step(1'b1, -100, 1'b0, 0, 0);
      for (int i = 0; i < 11; i++) step(1'b1, 0, 1'b0, 0, 0);
      idle(3);

      phase = "step";
      for (int i = 0; i < 14; i++) step(1'b1, 1000, 1'b0, 0, 0);
      idle(3);

      phase = "collision";
      do_reset();
      step(1'b1, 1000, 1'b1, 0, 0);
      step(1'b1, 500, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0, 0, 0);
      idle(3);

      phase = "saturate";
      do_reset();
      step(1'b0, 0, 1'b1, 0, 127);
      for (int i = 0; i < 12; i++) step(1'b1, 32767, 1'b0, 0, 0);
      for (int i = 0; i < 12; i++) step(1'b1, -32768, 1'b0, 0, 0);
      idle(3);

      phase = "gaps";
      do_reset();
      gap = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         rd = 16'($urandom);
         step(gap[i], rd, 1'b0, 0, 0);
      end
      idle(4);

      phase = "random";
      for (int i = 0; i < 80; i++) begin
         rd = 16'($urandom);
         rc = 8'($urandom);
         step(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) == 0), $urandom_range(0, 7), rc);
      end
      idle(3);

      phase = "midstream_reset";
      for (int i = 0; i < 3; i++) step(1'b1, 2000 + i, 1'b1, i, -20);
      do_reset();
      idle(4);
      step(1'b1, 100, 1'b0, 0, 0);
      for (int i = 0; i < 11; i++) step(1'b1, 0, 1'b0, 0, 0);
      idle(3);

      phase = "taps6_addr_range";
      b6.coef_we = 1'b1; b6.coef_addr = 3'd6; b6.coef_wdata = '0;
      idle(1);
      b6.coef_addr = 3'd7;
      idle(1);
      b6.coef_we  = 1'b0;
      b6.in_valid = 1'b1;
      b6.in_data  = 16'sd100;
      idle(1);
      b6.in_data = '0;
      for (int i = 0; i < 9; i++) begin
         idle(1);
         check("u6_out_valid", b6.out_valid, (i >= 1) ? 1 : 0);
         check("u6_out_data", $signed(b6.out_data), (i >= 1 && i <= 6) ? 13 : 0);
         check("u6_out_sat", b6.out_sat, 0);
      end
      b6.in_valid = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
Parametrised successor to the fixed 8-tap moving-average FIR. It is a direct-form FIR with a configurable tap count and data, coefficient and output widths, and run-time writable coefficients. It adds a sample-valid handshake, a 3-stage pipelined datapath, and round-half-up scaling with output saturation. It sits in the sample stream between the ADC/sample source and downstream DSP.

Parameters:
TAPS, 8, number of taps (2..32); delay line holds TAPS-1 past samples
DATA_W, 16, signed input sample width
COEF_W, 8, signed coefficient width
OUT_W, 16, signed output width after scaling
SHIFT, 7, arithmetic right shift applied to the accumulator (1..ACC_W-1)
COEF_RST, 16, value loaded into every coefficient on reset

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
in_valid  in  1  sample strobe; in_data accepted on any edge where in_valid=1
in_data  in  DATA_W  signed input sample
coef_we  in  1  coefficient write enable
coef_addr  in  clog2(TAPS)  coefficient index; 0 multiplies the newest sample
coef_wdata  in  COEF_W  signed coefficient value
out_valid  out  1  output strobe
out_data  out  OUT_W  signed filtered, scaled, saturated sample
out_sat  out  1  high with out_valid when out_data was clipped

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset clears the delay line, all pipeline registers, out_valid, out_data and out_sat to 0, and sets every coefficient to COEF_RST. Reset has priority over in_valid and coef_we.
- Reset mid-stream discards in-flight samples: out_valid is 0 in the cycle after reset, and no stale outputs appear afterwards.
- Widths: ACC_W = DATA_W + COEF_W + clog2(TAPS); products are DATA_W+COEF_W. All arithmetic is signed, with no overflow possible before scaling.
- Stage 1, on an edge with in_valid=1:
  - x[0] <= in_data, x[k] <= x[k-1].
  - p[k] <= coef[k] * xn[k], where xn[0] = in_data and xn[k] = x[k-1].
  - v1 <= in_valid. When in_valid=0, the delay line holds.
- Stage 2: acc <= sum of p[0..TAPS-1]; v2 <= v1.
- Stage 3: r = (acc + 2^(SHIFT-1)) >>> SHIFT.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat <= (clamped != r); out_data <= clamped; out_valid <= v2.
- Latency: in_valid high in cycle t gives out_valid high in cycle t+3. Throughput is one sample per cycle with no backpressure. Gaps in in_valid produce matching gaps in out_valid.
- When out_valid=0, out_data and out_sat hold their last values.
- Coefficient write: coef[coef_addr] updates at the edge where coef_we=1. A sample accepted at that same edge uses the old coefficient; samples accepted at later edges use the new one.
- coef_addr >= TAPS: the write is ignored.

Decomposition:
- Shared package: ACC_W and product-width functions, a clog2 function, and a saturate-to-N-bits function.
- One natural sub-module: fir_round_sat. It is combinational: ACC_W in, OUT_W out plus a sat flag, parametrised by SHIFT.
- Delay line, coefficient bank and adder stay in the top module.

Test Plan:
- Impulse: reset, then in_data=100 for one valid cycle followed by zeros. Expect exactly 8 outputs of 13 (1600+64>>>7) starting 3 cycles later, then 0; out_sat=0.
- Negative impulse: -100 gives 8 outputs of -12. Step: 1000 held valid gives a ramp 125, 250, ..., 1000, then steady 1000.
- Saturation: write coef[0]=127 and hold in_data=32767. Expect steady out_data=32767 with out_sat=1. With in_data=-32768, expect -32768 with out_sat=1.
- Coefficient write collision: coef_we (addr 0, value 0) on the same edge as sample A, with sample B on the next edge. A's contribution uses 16 and B's uses 0; check the resulting sums exactly. A write to addr>=TAPS (TAPS=6 build) changes nothing.
- Valid gaps: the pattern 1,0,0,1,1,0,1 on in_valid gives the same pattern on out_valid delayed 3 cycles. Values equal those of a gapless stream of the same samples.
- Reset mid-operation: assert RST for 1 cycle while 3 samples are in flight. No out_valid follows, coefficients return to 16, and the next impulse reproduces the first test.
